// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared geometry, controller state encoding and line helpers
//               for the direct-mapped write-through cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  localparam int TAG_W  = 6;
  localparam int IDX_W  = 3;
  localparam int WORD_W = 10;
  localparam int LINE_W = 20;
  localparam int LINES  = 8;
  localparam int ADDR_W = 10;

  // Controller states, explicitly encoded
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_FILL   = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // Replace one word of a line; offset 1 selects the upper word
  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic              off,
                                                   input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] w_res;
    w_res = line;
    if (off) w_res[LINE_W-1:WORD_W] = word;
    else     w_res[WORD_W-1:0]      = word;
    return w_res;
  endfunction

  // Extract one word of a line
  function automatic logic [WORD_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                  input logic              off);
    return off ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_if
// Description : Memory-side handshake. mem_req is held until memory reports
//               busy (mem_ready=0), then dropped; the transfer completes on
//               the first cycle mem_ready is seen high again. Address, write
//               enable and write data are held stable for the whole transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_if
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              o_done,
  output logic [LINE_W-1:0] o_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_REQ  = 2'd1;
  localparam logic [1:0] M_WAIT = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       w_accept;

  // A new transfer may start from idle or back-to-back on a completion cycle
  assign w_accept = i_start && ((r_state == M_IDLE) || o_done);

  // Handshake state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= M_IDLE;
    else     r_state <= w_next;
  end

  // Handshake next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      M_IDLE:  if (w_accept) w_next = M_REQ;
      M_REQ:   if (!mem_ready) w_next = M_WAIT;
      M_WAIT:  if (mem_ready) w_next = w_accept ? M_REQ : M_IDLE;
      default: w_next = M_IDLE;
    endcase
  end

  // Handshake outputs; read data is captured by the caller on o_done
  always_comb begin
    mem_req = (r_state == M_REQ);
    o_done  = (r_state == M_WAIT) && mem_ready;
    o_rdata = mem_rdata;
  end

  // Transfer attributes latched at start, write enable cleared on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (w_accept) begin
      mem_we    <= i_we;
      mem_addr  <= i_addr;
      mem_wdata <= i_wdata;
    end else if (o_done) begin
      mem_we    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl
// Description : Direct-mapped, write-through / write-allocate cache
//               controller, 8 lines x 2 words x 10 bits.
//               Optional macro CACHE_STATS_EN adds saturating hit/miss
//               counters on outputs hit_count / miss_count.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  state_t            r_state, w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;

  logic [LINE_W-1:0] r_data [LINES];
  logic [TAG_W-1:0]  r_tags [LINES];
  logic [LINES-1:0]  r_valid;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic              w_off;
  logic              w_hit;
  logic              w_done;
  logic [LINE_W-1:0] w_fill_line;
  logic [LINE_W-1:0] w_cur_line;
  logic              w_start, w_start_we;
  logic [LINE_W-1:0] w_start_line;
  logic              w_arr_we, w_fill_done;
  logic [LINE_W-1:0] w_arr_line;

  assign w_tag      = r_addr[ADDR_W-1:ADDR_W-TAG_W];
  assign w_idx      = r_addr[IDX_W:1];
  assign w_off      = r_addr[0];
  assign w_cur_line = r_data[w_idx];
  assign w_hit      = r_valid[w_idx] && (r_tags[w_idx] == w_tag);

  cache_mem_if u_mem_if (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_we      (w_start_we),
    .i_addr    ({w_tag, w_idx, 1'b0}),
    .i_wdata   (w_start_line),
    .o_done    (w_done),
    .o_rdata   (w_fill_line),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Controller next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (cpu_req) w_next = S_LOOKUP;
      S_LOOKUP: w_next = !w_hit ? S_FILL : (r_we ? S_WRITE : S_IDLE);
      S_FILL:   if (w_done) w_next = r_we ? S_WRITE : S_RESP;
      S_WRITE:  if (w_done) w_next = S_IDLE;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Controller outputs: transfer launches and array write strobes
  always_comb begin
    cpu_ready    = (r_state == S_IDLE);
    w_start      = 1'b0;
    w_start_we   = 1'b0;
    w_start_line = merge_word(w_cur_line, w_off, r_wdata);
    w_arr_we     = 1'b0;
    w_arr_line   = merge_word(w_cur_line, w_off, r_wdata);
    w_fill_done  = 1'b0;
    case (r_state)
      S_LOOKUP: begin
        if (!w_hit) begin
          w_start = 1'b1;
        end else if (r_we) begin
          w_start    = 1'b1;
          w_start_we = 1'b1;
          w_arr_we   = 1'b1;
        end
      end
      S_FILL: begin
        if (w_done) begin
          // A write miss merges straight into the fetched line and
          // launches the write-through back-to-back
          w_fill_done  = 1'b1;
          w_arr_we     = 1'b1;
          w_arr_line   = r_we ? merge_word(w_fill_line, w_off, r_wdata) : w_fill_line;
          w_start      = r_we;
          w_start_we   = r_we;
          w_start_line = merge_word(w_fill_line, w_off, r_wdata);
        end
      end
      default: ;
    endcase
  end

  // Latch the accepted CPU request; requests while busy are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if ((r_state == S_IDLE) && cpu_req) begin
      r_we    <= cpu_we;
      r_addr  <= cpu_addr;
      r_wdata <= cpu_wdata;
    end
  end

  // Line data and tag storage (no reset needed, guarded by valid bits)
  always_ff @(posedge clk) begin
    if (w_arr_we)    r_data[w_idx] <= w_arr_line;
    if (w_fill_done) r_tags[w_idx] <= w_tag;
  end

  // Valid bits; reset also invalidates any line whose fill was aborted
  always_ff @(posedge clk) begin
    if (rst)              r_valid        <= '0;
    else if (w_fill_done) r_valid[w_idx] <= 1'b1;
  end

  // Registered read data for hits and read-miss fills
  always_ff @(posedge clk) begin
    if (rst)
      cpu_rdata <= '0;
    else if ((r_state == S_LOOKUP) && w_hit && !r_we)
      cpu_rdata <= pick_word(w_cur_line, w_off);
    else if ((r_state == S_FILL) && w_done && !r_we)
      cpu_rdata <= pick_word(w_fill_line, w_off);
  end

`ifdef CACHE_STATS_EN
  // Saturating hit/miss counters, one update per lookup
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit && (hit_count != 16'hFFFF))    hit_count  <= hit_count + 16'd1;
      if (!w_hit && (miss_count != 16'hFFFF))  miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl
// Description : Self-checking bench for cache_ctrl with a one-busy-cycle
//               memory model and a read-data scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl;

  localparam int LIMIT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [9:0]  cpu_addr = '0;
  logic [9:0]  cpu_wdata = '0;
  logic [9:0]  cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [19:0] mem_wdata;
  logic [19:0] mem_rdata = '0;
  logic        mem_ready = 1'b1;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q [$];

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // Memory model: one busy cycle per transfer, word-addressed storage
  logic [9:0]  mem [1024];
  logic        mem_init = 1'b0;
  logic [9:0]  m_addr = '0;
  logic        m_we = 1'b0;
  logic [19:0] m_wdata = '0;
  int          n_mreq = 0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 10'(i + 'h100);
      mem[6]   <= 10'h057;
      mem[7]   <= 10'h061;
      mem[22]  <= 10'h065;
      mem_init <= 1'b1;
    end else if (mem_ready && mem_req) begin
      mem_ready <= 1'b0;
      m_addr    <= mem_addr;
      m_we      <= mem_we;
      m_wdata   <= mem_wdata;
      n_mreq    <= n_mreq + 1;
    end else if (!mem_ready) begin
      if (m_we) begin
        mem[m_addr]         <= m_wdata[9:0];
        mem[m_addr | 10'd1] <= m_wdata[19:10];
      end else begin
        mem_rdata <= {mem[m_addr | 10'd1], mem[m_addr]};
      end
      mem_ready <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One CPU access; optionally pulses a stray write request while busy
  task automatic access(input string tag, input logic we, input logic [9:0] addr,
                        input logic [9:0] wdata, input logic [9:0] exp_rd,
                        input int exp_reqs, input bit exp_hit, input bit inject);
    int reqs0;
    int lat;
    logic [9:0] exp_v;
    reqs0 = n_mreq;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    if (!we) exp_q.push_back(exp_rd);
    @(negedge clk);
    cpu_req = 1'b0;
    lat = 1;
    chk({tag, "_busy"}, 32'(cpu_ready), 32'd0);
    while (!cpu_ready && lat < LIMIT) begin
      if (inject && lat == 2) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h002; cpu_wdata = 10'h155;
      end else begin
        cpu_req = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    cpu_req = 1'b0;
    chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
    if (exp_hit) chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_mreqs"}, 32'(n_mreq - reqs0), 32'(exp_reqs));
    if (!we && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(exp_v));
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready",  32'(cpu_ready), 32'd1);
    chk("rst_rdata",  32'(cpu_rdata), 32'd0);
    chk("rst_mreq",   32'(mem_req),   32'd0);
    chk("rst_mwe",    32'(mem_we),    32'd0);
    chk("rst_maddr",  32'(mem_addr),  32'd0);
    chk("rst_mwdata", 32'(mem_wdata), 32'd0);

    // Read miss fills line 3, then the other word hits
    access("rd006", 1'b0, 10'h006, 10'h000, 10'h057, 1, 1'b0, 1'b0);
    chk("rd006_maddr", 32'(mem_addr), 32'h006);
`ifdef CACHE_STATS_EN
    chk("rd006_miss_cnt", 32'(miss_count), 32'd1);
    chk("rd006_hit_cnt",  32'(hit_count),  32'd0);
`endif
    access("rd007", 1'b0, 10'h007, 10'h000, 10'h061, 0, 1'b1, 1'b0);

    // Write hit goes through with the merged line
    access("wr007", 1'b1, 10'h007, 10'h3FF, 10'h000, 1, 1'b0, 1'b0);
    chk("wr007_maddr",  32'(m_addr),  32'h006);
    chk("wr007_mwdata", 32'(m_wdata), 32'({10'h3FF, 10'h057}));
    chk("wr007_mem",    32'(mem[7]),  32'h3FF);
    chk("wr007_mwe_off", 32'(mem_we), 32'd0);
    access("rd007b", 1'b0, 10'h007, 10'h000, 10'h3FF, 0, 1'b1, 1'b0);

    // Write miss allocates then writes through
    access("wr00B", 1'b1, 10'h00B, 10'h1A5, 10'h000, 2, 1'b0, 1'b0);
    chk("wr00B_mwdata", 32'(m_wdata), 32'({10'h1A5, 10'h10A}));
    access("rd00A", 1'b0, 10'h00A, 10'h000, 10'h10A, 0, 1'b1, 1'b0);
    access("rd00B", 1'b0, 10'h00B, 10'h000, 10'h1A5, 0, 1'b1, 1'b0);

    // Conflict eviction on index 3
    access("rd016", 1'b0, 10'h016, 10'h000, 10'h065, 1, 1'b0, 1'b0);
    chk("rd016_maddr", 32'(m_addr), 32'h016);
    access("rd006_evict", 1'b0, 10'h006, 10'h000, 10'h057, 1, 1'b0, 1'b0);

    // Reset while a fill is waiting on busy memory
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h016;
    @(negedge clk);
    cpu_req = 1'b0;
    lat = 0;
    while (mem_ready && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    chk("abort_mem_busy", 32'(mem_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mreq",  32'(mem_req),   32'd0);
    chk("abort_ready", 32'(cpu_ready), 32'd1);
    chk("abort_mwe",   32'(mem_we),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    access("rd006_post_rst", 1'b0, 10'h006, 10'h000, 10'h057, 1, 1'b0, 1'b0);

    // Stray request while busy must be ignored
    access("rd016_inject", 1'b0, 10'h016, 10'h000, 10'h065, 1, 1'b0, 1'b1);
    chk("inject_maddr", 32'(m_addr), 32'h016);
    chk("inject_mem2",  32'(mem[2]), 32'h102);
    @(negedge clk);
    chk("inject_idle", 32'(cpu_ready), 32'd1);
    access("rd002", 1'b0, 10'h002, 10'h000, 10'h102, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have rst  in  1  synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have cpu_req  in  1  CPU access request, sampled only while cpu_ready=1.
REQ-004 SHALL have cpu_we  in  1  1=write, 0=read, sampled with cpu_req.
REQ-005 SHALL have cpu_addr  in  10  word address: tag=[9:4], index=[3:1], offset=[0].
REQ-006 SHALL have cpu_wdata  in  10  write word.
REQ-007 SHALL have cpu_rdata  out  10  read word, registered, valid while cpu_ready=1 after a read.
REQ-008 SHALL have cpu_ready  out  1  1=idle and accepting; 0=busy.
REQ-009 SHALL have mem_req  out  1  memory request.
REQ-010 SHALL have mem_we  out  1  memory write enable.
REQ-011 SHALL have mem_addr  out  10  memory address, bit 0 always 0 (line aligned).
REQ-012 SHALL have mem_wdata  out  20  line write data, {word1, word0}.
REQ-013 SHALL have mem_rdata  in  20  line read data, {word1, word0}; the top level ties mem_wdata/mem_rdata to the shared 20-bit tristate bus.
REQ-014 SHALL have mem_ready  in  1  memory status, 1=idle, goes 0 for the busy cycle(s), returns 1 on completion.

Function
REQ-015 SHALL be direct-mapped: 8 lines x 2 words x 10 bits, with a 6-bit tag and 1 valid bit per line.
REQ-016 SHALL use states IDLE, LOOKUP, FILL, WRITE, RESP.
REQ-017 SHALL accept a request in IDLE when cpu_req=1: latch we/addr/wdata, drop cpu_ready next cycle, enter LOOKUP.
REQ-018 In LOOKUP, hit SHALL mean valid[index] and tag match.
REQ-019 On a read hit, SHALL load cpu_rdata and return to IDLE with cpu_ready=1 two cycles after acceptance.
REQ-020 On any miss, SHALL enter FILL: read the line at {tag,index,0}, write it into the array, set valid and tag.
REQ-021 On a read miss, SHALL return FILL data to the CPU on the FILL completion cycle and go to RESP then IDLE.
REQ-022 SHALL be write-through with write-allocate: a write hit merges cpu_wdata into the line and enters WRITE; a write miss goes through FILL first, then merges and enters WRITE.
REQ-023 WRITE SHALL issue mem_we=1 with the full merged line, and the cache array SHALL be updated in the same cycle.
REQ-024 Memory handshake: mem_req SHALL be held at 1 until mem_ready is sampled 0, then dropped to 0; the transfer SHALL complete on the first cycle mem_ready is sampled 1 after that.
REQ-025 mem_addr, mem_we and mem_wdata SHALL remain stable from mem_req rising until completion; mem_rdata SHALL be captured at completion.
REQ-026 mem_we SHALL be 0 whenever no write is in flight.
REQ-027 cpu_req while cpu_ready=0 SHALL be ignored and not queued.
REQ-028 A second access to the other word of a freshly filled line SHALL hit.

Reset
REQ-029 On rst: state=IDLE; all valid bits=0; cpu_ready=1; cpu_rdata=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0.
REQ-030 rst during FILL or WRITE SHALL abort the transfer immediately, drop mem_req, and leave no line valid.
REQ-031 Array data and tags need no reset.

Configuration
REQ-032 With CACHE_STATS_EN defined, SHALL add outputs hit_count[15:0] and miss_count[15:0], incremented once per LOOKUP, saturating at 0xFFFF, cleared by rst.
REQ-033 Without CACHE_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 Package cache_pkg SHALL hold the state enum, TAG_W=6, IDX_W=3, WORD_W=10, LINE_W=20 and LINES=8.
REQ-035 Sub-module cache_mem_if SHALL implement the REQ-024/025 handshake (start, we, addr, wdata in; done, rdata out).

Verification (memory model: 1 busy cycle, word6=0x057, word7=0x061, word22=0x065)
REQ-036 Reset, then read 0x006 SHALL give a miss, one mem_req read at 0x006, cpu_rdata=0x057, and miss_count=1.
REQ-037 Then read 0x007 SHALL hit with no mem_req, cpu_rdata=0x061, and cpu_ready back at 1 two cycles after acceptance.
REQ-038 Write 0x3FF to 0x007 SHALL write through at mem_addr=0x006 with mem_wdata={0x3FF,0x057}; a following read of 0x007 SHALL hit and return 0x3FF.
REQ-039 Read 0x016 (same index 3, tag 1) SHALL evict the line, return 0x065, and a later read of 0x006 SHALL miss again.
REQ-040 Assert rst while in FILL with mem_ready=0; the bench SHALL check mem_req=0 and cpu_ready=1 next cycle, and that a read of 0x006 then misses.
REQ-041 Pulse cpu_req with a different address while busy; the bench SHALL check the request is ignored and that only the original access completes.
